// File: rtl/bus_pkg.sv
// Shared defaults and register map for the regional NoC return path.
// Register window: DATA (pop), STATUS, CTRL (flush / clear).
package bus_pkg;

  localparam int DEF_WB_WID  = 32;
  localparam int DEF_NOC_WID = 16;
  localparam int DEF_RA_WID  = 9;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  localparam int STAT_OVF     = 31;
  localparam int STAT_DROP_LO = 16;
  localparam int STAT_DROP_W  = 15;
  localparam int STAT_CNT_W   = 16;

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// Flush has priority over a same-cycle push or pop.
module sync_fifo #(
  parameter int W = 25,
  parameter int D = 8,
  localparam int AW = $clog2(D),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdat,
  output logic [W-1:0]  rdat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(D));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdat    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_collector.sv
// Collects tagged regional responses into a FIFO behind a Wishbone window.
// Optional drop counter: define BUS_COLLECTOR_DROP_CNT_EN.
module bus_collector
  import bus_pkg::*;
#(
  parameter int WB_WID            = DEF_WB_WID,
  parameter int NOC_WID           = DEF_NOC_WID,
  parameter int REGIONAL_ADDR_WID = DEF_RA_WID,
  parameter int DEPTH             = 8,
  parameter logic [WB_WID-1:0] ADDR_LO = 32'h0000_1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [NOC_WID-1:0]           in_dat,
  input  logic [REGIONAL_ADDR_WID-1:0] in_adr,
  input  logic                         wb_cyc,
  input  logic                         wb_stb,
  input  logic                         wb_we,
  input  logic [WB_WID-1:0]            wb_adr,
  input  logic [WB_WID-1:0]            wb_dat_i,
  output logic [WB_WID-1:0]            wb_dat_o,
  output logic                         wb_ack
);

  localparam int EW = REGIONAL_ADDR_WID + NOC_WID;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [WB_WID-1:0] ADDR_HI = ADDR_LO + WB_WID'(3);

  state_t             state;
  logic [EW-1:0]      head;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               ovf;
  logic [WB_WID-1:0]  diff;
  logic [1:0]         off;
  logic               hit;
  logic               acc;
  logic               pop;
  logic               ctl_wr;
  logic               flush;
  logic               clr;
  logic               push;
  logic               drop;
  logic [WB_WID-1:0]  rd_val;
  logic [STAT_DROP_W-1:0] drop_cnt;
  logic               unused_ok;

  assign diff   = wb_adr - ADDR_LO;
  assign off    = diff[1:0];
  assign hit    = wb_cyc && wb_stb &&
                  (wb_adr >= ADDR_LO) && (wb_adr < ADDR_HI);
  assign acc    = (state == IDLE) && hit;
  assign pop    = acc && !wb_we && (off == OFF_DATA);
  assign ctl_wr = acc && wb_we && (off == OFF_CTRL);
  assign flush  = ctl_wr && wb_dat_i[CTRL_FLUSH];
  assign clr    = ctl_wr && wb_dat_i[CTRL_CLR];
  assign in_rdy = !full;
  assign push   = in_vld && in_rdy;
  // a push lost to a flush is discarded, not an overflow
  assign drop   = in_vld && !in_rdy && !flush;

  assign unused_ok = ^{wb_dat_i, diff};

  sync_fifo #(
    .W (EW),
    .D (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdat  ({in_adr, in_dat}),
    .rdat  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef BUS_COLLECTOR_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (clr)
      drop_cnt <= '0;
    else if (drop && (drop_cnt != '1))
      drop_cnt <= drop_cnt + STAT_DROP_W'(1);
  end
`else
  assign drop_cnt = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (clr)
      ovf <= 1'b0;
    else if (drop)
      ovf <= 1'b1;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (!wb_we && off == OFF_DATA): begin
        if (!empty) begin
          rd_val[WB_WID-1] = 1'b1;
          rd_val[EW-1:0]   = head;
        end
      end
      (!wb_we && off == OFF_STATUS): begin
        rd_val[STAT_OVF] = ovf;
        rd_val[STAT_DROP_LO +: STAT_DROP_W] = drop_cnt;
        rd_val[STAT_CNT_W-1:0] = STAT_CNT_W'(count);
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            wb_dat_o <= rd_val;
            wb_ack   <= 1'b1;
            state    <= ACK;
          end
        end
        ACK: begin
          wb_ack <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          wb_ack <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_collector.sv
// Directed self-checking bench for bus_collector.
// Expected words are hand-computed from the register map.
module tb_bus_collector;

  logic        clk;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic [15:0] in_dat;
  logic [8:0]  in_adr;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;

  int passed = 0;
  int total  = 0;

`ifdef BUS_COLLECTOR_DROP_CNT_EN
  localparam logic [31:0] STAT_FULL = 32'h8001_0008;
`else
  localparam logic [31:0] STAT_FULL = 32'h8000_0008;
`endif

  bus_collector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_dat   (in_dat),
    .in_adr   (in_adr),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack   (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] a, input logic [15:0] d);
    in_vld = 1'b1;
    in_adr = a;
    in_dat = d;
    step();
    in_vld = 1'b0;
  endtask

  // one Wishbone access; optional same-cycle push of (pa, pd)
  task automatic acc(input string tag,
                     input logic [31:0] a,
                     input logic we,
                     input logic [31:0] d,
                     input logic chk_dat,
                     input logic [31:0] exp,
                     input logic with_push,
                     input logic [8:0] pa,
                     input logic [15:0] pd);
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_adr   = a;
    wb_dat_i = d;
    if (with_push) begin
      in_vld = 1'b1;
      in_adr = pa;
      in_dat = pd;
    end
    step();
    in_vld = 1'b0;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    check({tag, "_ack"}, 32'(wb_ack), 32'd1);
    if (chk_dat)
      check(tag, wb_dat_o, exp);
    step();
    check({tag, "_ack1"}, 32'(wb_ack), 32'd0);
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    acc(tag, a, 1'b0, 32'h0, 1'b1, exp, 1'b0, 9'h0, 16'h0);
  endtask

  task automatic wr(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] d);
    acc(tag, a, 1'b1, d, 1'b0, 32'h0, 1'b0, 9'h0, 16'h0);
  endtask

  task automatic miss(input string tag,
                      input logic [31:0] a,
                      input logic [31:0] held);
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = 1'b0;
    wb_adr = a;
    for (int i = 0; i < 2; i++) begin
      step();
      check({tag, "_ack"}, 32'(wb_ack), 32'd0);
      check({tag, "_dat"}, wb_dat_o, held);
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_vld   = 1'b0;
    in_dat   = '0;
    in_adr   = '0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_adr   = '0;
    wb_dat_i = '0;
    step();
    check("rst_rdy", 32'(in_rdy), 32'd1);
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_dat", wb_dat_o, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // reset mid-push with three entries queued
    push(9'h001, 16'h0011);
    push(9'h002, 16'h0022);
    push(9'h003, 16'h0033);
    in_vld = 1'b1;
    in_adr = 9'h004;
    in_dat = 16'h0044;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", 32'(in_rdy), 32'd1);
    check("midrst_ack", 32'(wb_ack), 32'd0);
    step();
    in_vld = 1'b0;
    rst_n  = 1'b1;
    step();
    rd("rst_status", 32'h1001, 32'h0000_0000);

    // ordering
    push(9'h005, 16'hBEEF);
    push(9'h1FF, 16'h0001);
    rd("ord0", 32'h1000, 32'h8005_BEEF);
    rd("ord1", 32'h1000, 32'h81FF_0001);

    // empty read
    rd("empty_rd", 32'h1000, 32'h0000_0000);
    rd("empty_status", 32'h1001, 32'h0000_0000);

    // fill past full with in_vld held
    in_vld = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_adr = 9'(i);
      in_dat = 16'(i);
      step();
      if (i == 6)
        check("rdy_at7", 32'(in_rdy), 32'd1);
      if (i == 7)
        check("rdy_at8", 32'(in_rdy), 32'd0);
    end
    in_vld = 1'b0;
    rd("full_status", 32'h1001, STAT_FULL);

    // out-of-window accesses
    miss("dec_1003", 32'h1003, STAT_FULL);
    miss("dec_0fff", 32'h0FFF, STAT_FULL);
    rd("dec_status", 32'h1001, STAT_FULL);

    // drain four, then flush+clear with a simultaneous push
    for (int i = 0; i < 4; i++)
      rd("drain", 32'h1000, 32'h8000_0000 | (32'(i) << 16) | 32'(i));
    rd("pre_flush", 32'h1001, 32'h8000_0004 | (STAT_FULL & 32'h7FFF_0000));
    acc("flush", 32'h1002, 1'b1, 32'h3, 1'b0, 32'h0, 1'b1, 9'h077, 16'h7777);
    rd("post_flush", 32'h1001, 32'h0000_0000);

    // push and pop in the same cycle at count 5
    for (int i = 0; i < 5; i++)
      push(9'h010 + 9'(i), 16'h0100 + 16'(i));
    rd("cnt5", 32'h1001, 32'h0000_0005);
    acc("pp5", 32'h1000, 1'b0, 32'h0, 1'b1, 32'h8010_0100, 1'b1, 9'h01F, 16'h2222);
    rd("pp5_status", 32'h1001, 32'h0000_0005);
    rd("pp5_next", 32'h1000, 32'h8011_0101);
    wr("flush_only", 32'h1002, 32'h1);
    rd("flush_only_st", 32'h1001, 32'h0000_0000);

    // push and pop in the same cycle on an empty FIFO
    acc("pp0", 32'h1000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 9'h0AA, 16'h1234);
    rd("pp0_status", 32'h1001, 32'h0000_0001);

    // writes to DATA/STATUS and CTRL reads have no effect
    wr("wr_data", 32'h1000, 32'h3);
    wr("wr_status", 32'h1001, 32'h3);
    rd("ctrl_rd", 32'h1002, 32'h0000_0000);
    rd("noeff_status", 32'h1001, 32'h0000_0001);
    rd("pp0_entry", 32'h1000, 32'h80AA_1234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
